execute: RTL and testbench
==========================

# execute

Execute stage of the Y86-64 five-stage pipeline. Consumes the E pipeline register driven by `decode`. Computes the ALU result, holds the condition-code register and evaluates branch/cmov conditions. Forwards `e_valE`/`e_dstE` back to `decode` and loads the M pipeline register consumed by the memory stage.

## Interface
Parameters:
- none. Widths are fixed: 64-bit data, 4-bit icode/ifun/register IDs, 4-bit one-hot stat.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `E_stat`  in  4  stat of the instruction in E; 1000 AOK, 0100 HLT, 0010 ADR, 0001 INS
- `E_icode`, `E_ifun`  in  4 each  instruction code and function
- `E_valC`, `E_valA`, `E_valB`  in  64 each  operands from decode
- `E_dstE`, `E_dstM`  in  4 each  destination register IDs; F = none
- `m_stat`, `W_stat`  in  4 each  stat of the younger-stage instructions, used to gate the CC update
- `M_bubble`  in  1  load a bubble into M this cycle
- `e_valE`  out  64  ALU result, combinational, forwarded to decode
- `e_dstE`  out  4  effective dstE, combinational; F when a cmov is not taken
- `e_Cnd`  out  1  condition result, combinational
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  condition-code register
- `M_stat`, `M_icode`  out  4 each  M register
- `M_Cnd`  out  1  M register
- `M_valE`, `M_valA`  out  64 each  M register
- `M_dstE`, `M_dstM`  out  4 each  M register

## Operation
- aluA selection:
  - `E_valA` for icode 2 and 6
  - `E_valC` for icode 3, 4 and 5
  - -8 for icode 8 and A
  - +8 for icode 9 and B
  - 0 otherwise
- aluB selection:
  - `E_valB` for icode 4, 5, 6, 8, 9, A and B
  - 0 otherwise
- alufun is `E_ifun` for icode 6 and ADD for every other icode.
- ALU functions:
  - 0 ADD: B+A
  - 1 SUB: B−A
  - 2 AND: B&A
  - 3 XOR: B^A
  - any other ifun on icode 6 gives result 0 and no CC write
- All arithmetic is 64-bit modulo 2^64.
- New flags:
  - ZF: result == 0
  - SF: result[63]
  - OF for ADD: sign(A) == sign(B) and sign(result) != sign(A)
  - OF for SUB: sign(A) != sign(B) and sign(result) != sign(B)
  - OF for AND/XOR: 0
- set_cc requires all three: E_icode == 6, `m_stat` ∉ {ADR, INS, HLT}, and `W_stat` ∉ {ADR, INS, HLT}.
- Conditions on the **current** CC register, keyed by `E_ifun`:
  - 0: always
  - 1 LE: (SF^OF)|ZF
  - 2 L: SF^OF
  - 3 E: ZF
  - 4 NE: !ZF
  - 5 GE: !(SF^OF)
  - 6 G: !(SF^OF)&!ZF
  - 7–F: 0
- `e_Cnd` is meaningful only for icode 2 and 7; it is driven 0 for all other icodes.
- `e_dstE` = F when E_icode == 2 and !e_Cnd; otherwise `e_dstE` = `E_dstE`.
- M load, normal: stat, icode, Cnd, valE and valA are copied; dstE takes `e_dstE`; dstM takes `E_dstM`.
- M load, bubble: stat 1000, icode 1, Cnd 0, valE 0, valA 0, dstE F, dstM F.

## Timing
- Reset (asynchronous, takes effect immediately):
  - CC register: ZF=1, SF=0, OF=0
  - M register: bubble values as listed under Operation
- `e_valE`, `e_dstE` and `e_Cnd` settle in the same cycle as the E inputs, with zero latency.
- M register: 1-cycle latency.
- CC update: written on the rising edge when set_cc is true. The instruction entering E on the next cycle sees the new flags. An OPq immediately followed by a jXX or cmov therefore needs no stall.
- `e_Cnd` in the cycle of an OPq uses the **old** flags.
- `M_bubble` and `E_icode` == 6 in the same cycle: M takes the bubble. The CC write still follows set_cc; the controller must squash via `m_stat`/`W_stat`.
- Reset deasserted mid-stream: the first edge after deassertion loads M from the E inputs normally.

## Configuration
- `EXEC_PERF_CNT_EN`, defined: adds three 32-bit output ports, each reset to 0 and saturating at 0xFFFFFFFF.
  - `perf_alu_ops`: count of set_cc cycles
  - `perf_m_bubbles`: count of edges with `M_bubble`
  - `perf_cmov_squash`: count of edges that load M with E_icode == 2 and !e_Cnd
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset: assert `rst` mid-cycle → ZF=1, SF=0, OF=0 and M holds bubble values immediately, with no clock edge needed.
- OPq ADD, A=0x7FFFFFFFFFFFFFFF, B=1 → e_valE=0x8000000000000000; after the edge ZF=0, SF=1, OF=1.
- OPq SUB, A=5, B=5, then cmovE (icode 2, ifun 3, dstE=3) on the next cycle → ZF=1 and e_Cnd=1, e_dstE=3; with ifun 4 (NE) instead → e_dstE=F, M_dstE=F.
- OPq with `m_stat`=0010 (ADR) → e_valE is still computed, the CC register is unchanged, and M_valE holds the result.
- call (icode 8), valB=0x100 → e_valE=0xF8. ret (icode 9), valB=0xF8 → e_valE=0x100. Neither touches the CC register.
- `M_bubble`=1 with E holding irmovq valC=42 → M_icode=1, M_stat=1000, M_dstE=F. With `EXEC_PERF_CNT_EN` defined, `perf_m_bubbles` increments by 1.

Source files
------------

// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute -- Y86-64 pipeline execute stage
//
// Takes the E pipeline register from decode. Selects ALU operands, computes the
// ALU result and new flags, holds the condition-code register, evaluates the
// jXX/cmov condition against the current flags, forwards e_valE/e_dstE to
// decode and loads the M pipeline register for the memory stage.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   E_*                 E pipeline register (stat, icode, ifun, valC/A/B, dstE/M)
//   m_stat, W_stat      stat of younger-stage instructions; gate the CC write
//   M_bubble            load a bubble into M on this edge
//   e_valE, e_dstE      combinational ALU result / effective dstE (to decode)
//   e_Cnd               combinational condition result (icode 2 and 7 only)
//   cc_zf/cc_sf/cc_of   condition-code register
//   M_*                 M pipeline register
//
// Optional feature: define EXEC_PERF_CNT_EN to add three saturating 32-bit
// counters (perf_alu_ops, perf_m_bubbles, perf_cmov_squash).
// -----------------------------------------------------------------------------
module execute (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  E_stat,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_ifun,
   input  logic [63:0] E_valC,
   input  logic [63:0] E_valA,
   input  logic [63:0] E_valB,
   input  logic [3:0]  E_dstE,
   input  logic [3:0]  E_dstM,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  W_stat,
   input  logic        M_bubble,
   output logic [63:0] e_valE,
   output logic [3:0]  e_dstE,
   output logic        e_Cnd,
   output logic        cc_zf,
   output logic        cc_sf,
   output logic        cc_of,
   output logic [3:0]  M_stat,
   output logic [3:0]  M_icode,
   output logic        M_Cnd,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM
`ifdef EXEC_PERF_CNT_EN
   ,
   output logic [31:0] perf_alu_ops,
   output logic [31:0] perf_m_bubbles,
   output logic [31:0] perf_cmov_squash
`endif
);

   // Instruction codes
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] S_AOK = 4'b1000;
   localparam logic [3:0] S_HLT = 4'b0100;
   localparam logic [3:0] S_ADR = 4'b0010;
   localparam logic [3:0] S_INS = 4'b0001;
   localparam logic [3:0] R_NONE = 4'hF;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] val_e;
      logic [63:0] val_a;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
   } m_reg_t;

   localparam cc_t    CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};
   localparam m_reg_t M_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                                   val_e: 64'd0, val_a: 64'd0,
                                   dst_e: R_NONE, dst_m: R_NONE};

   function automatic logic stat_ok(input logic [3:0] s);
      return (s != S_HLT) && (s != S_ADR) && (s != S_INS);
   endfunction

   cc_t         cc_q, cc_d, cc_new;
   m_reg_t      m_q, m_d;
   logic [63:0] alu_a, alu_b, alu_res;
   logic [3:0]  alu_fun;
   logic        alu_fun_ok;
   logic        set_cc;
   logic        cond;

   // ---------------------------------------------------------------- ALU ---
   always_comb begin
      // NOTE: every variable gets a default at the top of the block so that no
      // path through the case statements can infer a latch.
      alu_a      = 64'd0;
      alu_b      = 64'd0;
      alu_res    = 64'd0;
      alu_fun_ok = 1'b1;
      cc_new     = cc_q;

      case (E_icode)
         I_RRMOVQ, I_OPQ:              alu_a = E_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
         I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;  // -8
         I_RET, I_POPQ:                alu_a = 64'd8;
         default:                      alu_a = 64'd0;
      endcase

      case (E_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
         default:                                                   alu_b = 64'd0;
      endcase

      alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

      case (alu_fun)
         ALU_ADD: alu_res = alu_b + alu_a;
         ALU_SUB: alu_res = alu_b - alu_a;
         ALU_AND: alu_res = alu_b & alu_a;
         ALU_XOR: alu_res = alu_b ^ alu_a;
         default: begin
            alu_res    = 64'd0;
            alu_fun_ok = 1'b0;
         end
      endcase

      cc_new.zf = (alu_res == 64'd0);
      cc_new.sf = alu_res[63];
      case (alu_fun)
         ALU_ADD: cc_new.of = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
         ALU_SUB: cc_new.of = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
         default: cc_new.of = 1'b0;
      endcase
   end

   // A faulting/halting instruction already in M or W must not see its
   // younger OPq change the flags.
   assign set_cc = (E_icode == I_OPQ) && alu_fun_ok && stat_ok(m_stat) && stat_ok(W_stat);
   assign cc_d   = set_cc ? cc_new : cc_q;

   // ---------------------------------------------------------- condition ---
   // Evaluated on the registered flags: an OPq in E this cycle has not yet
   // written them, so a jXX/cmov right behind it sees its flags next cycle.
   always_comb begin
      cond = 1'b0;
      case (E_ifun)
         4'h0:    cond = 1'b1;
         4'h1:    cond = (cc_q.sf ^ cc_q.of) | cc_q.zf;
         4'h2:    cond = cc_q.sf ^ cc_q.of;
         4'h3:    cond = cc_q.zf;
         4'h4:    cond = !cc_q.zf;
         4'h5:    cond = !(cc_q.sf ^ cc_q.of);
         4'h6:    cond = !(cc_q.sf ^ cc_q.of) && !cc_q.zf;
         default: cond = 1'b0;
      endcase
   end

   assign e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond : 1'b0;
   assign e_valE = alu_res;
   // A not-taken cmov must not write its destination register.
   assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? R_NONE : E_dstE;

   // --------------------------------------------------------- M register ---
   always_comb begin
      if (M_bubble) begin
         m_d = M_BUBBLE;
      end else begin
         m_d.stat  = E_stat;
         m_d.icode = E_icode;
         m_d.cnd   = e_Cnd;
         m_d.val_e = e_valE;
         m_d.val_a = E_valA;
         m_d.dst_e = e_dstE;
         m_d.dst_m = E_dstM;
      end
   end

   // NOTE: sequential state is assigned with non-blocking <= so every register
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc_q <= CC_RESET;
         m_q  <= M_BUBBLE;
      end else begin
         cc_q <= cc_d;
         m_q  <= m_d;
      end
   end

   assign cc_zf   = cc_q.zf;
   assign cc_sf   = cc_q.sf;
   assign cc_of   = cc_q.of;
   assign M_stat  = m_q.stat;
   assign M_icode = m_q.icode;
   assign M_Cnd   = m_q.cnd;
   assign M_valE  = m_q.val_e;
   assign M_valA  = m_q.val_a;
   assign M_dstE  = m_q.dst_e;
   assign M_dstM  = m_q.dst_m;

`ifdef EXEC_PERF_CNT_EN
   // ---------------------------------------------------- perf counters ---
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] alu_ops_q, alu_ops_d;
   logic [31:0] bubbles_q, bubbles_d;
   logic [31:0] squash_q,  squash_d;

   // A bubbled edge loads M with the bubble, not with the squashed cmov.
   assign alu_ops_d = set_cc   ? sat_inc(alu_ops_q) : alu_ops_q;
   assign bubbles_d = M_bubble ? sat_inc(bubbles_q) : bubbles_q;
   assign squash_d  = (!M_bubble && (E_icode == I_RRMOVQ) && !e_Cnd) ?
                      sat_inc(squash_q) : squash_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_ops_q <= 32'd0;
         bubbles_q <= 32'd0;
         squash_q  <= 32'd0;
      end else begin
         alu_ops_q <= alu_ops_d;
         bubbles_q <= bubbles_d;
         squash_q  <= squash_d;
      end
   end

   assign perf_alu_ops     = alu_ops_q;
   assign perf_m_bubbles   = bubbles_q;
   assign perf_cmov_squash = squash_q;
`endif

endmodule

// File: tb/tb_execute.sv
// -----------------------------------------------------------------------------
// tb_execute -- self-checking bench for the Y86-64 execute stage.
// Directed cases for the key scenarios, then randomized traffic checked against
// a behavioural model (wide signed arithmetic for the flags, plain flag state).
// -----------------------------------------------------------------------------
module tb_execute;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
   logic [63:0] E_valC, E_valA, E_valB;
   logic        M_bubble;
   logic [63:0] e_valE, M_valE, M_valA;
   logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
   logic        e_Cnd, cc_zf, cc_sf, cc_of, M_Cnd;
`ifdef EXEC_PERF_CNT_EN
   logic [31:0] perf_alu_ops, perf_m_bubbles, perf_cmov_squash;
   int unsigned ref_ops, ref_bub, ref_sq;
`endif

   execute dut (
      .clk(clk), .rst(rst),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM),
      .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
      .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
      .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
      .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
`ifdef EXEC_PERF_CNT_EN
      ,
      .perf_alu_ops(perf_alu_ops), .perf_m_bubbles(perf_m_bubbles),
      .perf_cmov_squash(perf_cmov_squash)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model flag state
   logic mzf, msf, mof;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_bubble_m(input string tag);
      check({tag, " M_stat"},  M_stat,  4'b1000);
      check({tag, " M_icode"}, M_icode, 4'h1);
      check({tag, " M_Cnd"},   M_Cnd,   1'b0);
      check({tag, " M_valE"},  M_valE,  64'd0);
      check({tag, " M_valA"},  M_valA,  64'd0);
      check({tag, " M_dstE"},  M_dstE,  4'hF);
      check({tag, " M_dstM"},  M_dstM,  4'hF);
   endtask

   function automatic logic bad_stat(input logic [3:0] s);
      return s == 4'b0100 || s == 4'b0010 || s == 4'b0001;
   endfunction

   task automatic set_e(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                        input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
      E_stat = 4'b1000; E_icode = ic; E_ifun = fn;
      E_valC = vc; E_valA = va; E_valB = vb; E_dstE = de; E_dstM = 4'hF;
      m_stat = 4'b1000; W_stat = 4'b1000; M_bubble = 1'b0;
   endtask

   // One cycle: inputs are already applied (clock low). Checks combinational
   // outputs against the model, clocks, then checks M and the flags.
   task automatic step();
      logic [63:0]        a, b, res;
      logic signed [64:0] w;
      logic [3:0]         fun, dste;
      logic               nof, valid, setcc, cnd, lt;

      case (E_icode)
         4'h2, 4'h6:       a = E_valA;
         4'h3, 4'h4, 4'h5: a = E_valC;
         4'h8, 4'hA:       a = 64'd0 - 64'd8;
         4'h9, 4'hB:       a = 64'd8;
         default:          a = 64'd0;
      endcase
      b   = (E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? E_valB : 64'd0;
      fun = (E_icode == 4'h6) ? E_ifun : 4'h0;
      valid = 1'b1; nof = 1'b0; res = 64'd0;
      case (fun)
         4'h0: begin w = $signed({b[63], b}) + $signed({a[63], a});
                     res = w[63:0]; nof = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) ||
                                          (w < -65'sh0_8000_0000_0000_0000); end
         4'h1: begin w = $signed({b[63], b}) - $signed({a[63], a});
                     res = w[63:0]; nof = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) ||
                                          (w < -65'sh0_8000_0000_0000_0000); end
         4'h2: res = b & a;
         4'h3: res = b ^ a;
         default: valid = 1'b0;
      endcase
      setcc = (E_icode == 4'h6) && valid && !bad_stat(m_stat) && !bad_stat(W_stat);

      lt = msf ^ mof;
      case (E_ifun)
         4'h0: cnd = 1'b1;
         4'h1: cnd = lt || mzf;
         4'h2: cnd = lt;
         4'h3: cnd = mzf;
         4'h4: cnd = !mzf;
         4'h5: cnd = !lt;
         4'h6: cnd = !lt && !mzf;
         default: cnd = 1'b0;
      endcase
      if (!(E_icode inside {4'h2, 4'h7})) cnd = 1'b0;
      dste = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;

      #1;
      check("e_valE", e_valE, res);
      check("e_Cnd",  e_Cnd,  cnd);
      check("e_dstE", e_dstE, dste);

      @(posedge clk); #1;
      if (M_bubble) begin
         check_bubble_m("bubble");
      end else begin
         check("M_stat",  M_stat,  E_stat);
         check("M_icode", M_icode, E_icode);
         check("M_Cnd",   M_Cnd,   cnd);
         check("M_valE",  M_valE,  res);
         check("M_valA",  M_valA,  E_valA);
         check("M_dstE",  M_dstE,  dste);
         check("M_dstM",  M_dstM,  E_dstM);
      end
      if (setcc) begin
         mzf = (res == 64'd0);
         msf = res[63];
         mof = nof;
      end
      check("cc_zf", cc_zf, mzf);
      check("cc_sf", cc_sf, msf);
      check("cc_of", cc_of, mof);
`ifdef EXEC_PERF_CNT_EN
      if (setcc) ref_ops++;
      if (M_bubble) ref_bub++;
      if (!M_bubble && E_icode == 4'h2 && !cnd) ref_sq++;
`endif
      @(negedge clk);
   endtask

   task automatic random_inputs();
      logic [3:0] stats [4];
      stats = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      E_stat  = stats[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 0) begin
         case ($urandom_range(0, 2))
            0: E_icode = 4'h2;
            1: E_icode = 4'h6;
            default: E_icode = 4'h7;
         endcase
      end else E_icode = 4'($urandom_range(0, 15));
      E_ifun  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      E_valC  = {$urandom, $urandom};
      E_valA  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0: E_valB = E_valA;                            // SUB/XOR to zero
         1: E_valB = {E_valA[63], 63'($urandom)};       // same-sign operands
         default: E_valB = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) E_valA = 64'd0;
      E_dstE  = 4'($urandom_range(0, 15));
      E_dstM  = 4'($urandom_range(0, 15));
      m_stat  = ($urandom_range(0, 3) == 0) ? stats[$urandom_range(0, 3)] : 4'b1000;
      W_stat  = ($urandom_range(0, 3) == 0) ? stats[$urandom_range(0, 3)] : 4'b1000;
      M_bubble = ($urandom_range(0, 7) == 0);
   endtask

   task automatic model_reset();
      mzf = 1'b1; msf = 1'b0; mof = 1'b0;
`ifdef EXEC_PERF_CNT_EN
      ref_ops = 0; ref_bub = 0; ref_sq = 0;
`endif
   endtask

   initial begin
`ifdef EXEC_PERF_CNT_EN
      logic [31:0] bub_before;
`endif
      rst = 1'b1;
      set_e(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      model_reset();
      @(negedge clk);
      check("reset cc_zf", cc_zf, 1'b1);
      check("reset cc_sf", cc_sf, 1'b0);
      check("reset cc_of", cc_of, 1'b0);
      check_bubble_m("reset");
      rst = 1'b0;

      // ADD overflow to negative
      set_e(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2);
      #1 check("add ovf e_valE", e_valE, 64'h8000_0000_0000_0000);
      step();
      check("add ovf zf", cc_zf, 1'b0);
      check("add ovf sf", cc_sf, 1'b1);
      check("add ovf of", cc_of, 1'b1);

      // SUB to zero, then cmovE taken / cmovNE not taken
      set_e(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2);
      step();
      check("sub zf", cc_zf, 1'b1);
      set_e(4'h2, 4'h3, 64'd0, 64'h1234, 64'd0, 4'h3);
      #1 check("cmovE cnd", e_Cnd, 1'b1);
      check("cmovE dstE", e_dstE, 4'h3);
      step();
      set_e(4'h2, 4'h4, 64'd0, 64'h1234, 64'd0, 4'h3);
      #1 check("cmovNE dstE", e_dstE, 4'hF);
      step();
      check("cmovNE M_dstE", M_dstE, 4'hF);

      // OPq while M holds an ADR fault: result computed, flags frozen
      set_e(4'h6, 4'h0, 64'd0, 64'd3, 64'd4, 4'h2);
      m_stat = 4'b0010;
      #1 check("adr e_valE", e_valE, 64'd7);
      step();
      check("adr zf kept", cc_zf, 1'b1);
      check("adr M_valE", M_valE, 64'd7);

      // call / ret stack-pointer arithmetic
      set_e(4'h8, 4'h0, 64'h40, 64'd0, 64'h100, 4'h4);
      #1 check("call e_valE", e_valE, 64'hF8);
      step();
      set_e(4'h9, 4'h0, 64'd0, 64'd0, 64'hF8, 4'h4);
      #1 check("ret e_valE", e_valE, 64'h100);
      step();
      check("call/ret zf kept", cc_zf, 1'b1);

      // Bubble over irmovq
`ifdef EXEC_PERF_CNT_EN
      bub_before = perf_m_bubbles;
`endif
      set_e(4'h3, 4'h0, 64'd42, 64'd0, 64'd0, 4'h5);
      M_bubble = 1'b1;
      step();
      check("bubble M_icode", M_icode, 4'h1);
      check("bubble M_stat", M_stat, 4'b1000);
      check("bubble M_dstE", M_dstE, 4'hF);
`ifdef EXEC_PERF_CNT_EN
      check("perf bubble +1", perf_m_bubbles, bub_before + 32'd1);
`endif

      for (int i = 0; i < 400; i++) begin
         random_inputs();
         step();
      end

      // Mid-cycle asynchronous reset
      #2 rst = 1'b1;
      #1;
      check("midrst cc_zf", cc_zf, 1'b1);
      check("midrst cc_sf", cc_sf, 1'b0);
      check("midrst cc_of", cc_of, 1'b0);
      check_bubble_m("midrst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 200; i++) begin
         random_inputs();
         step();
      end

`ifdef EXEC_PERF_CNT_EN
      check("perf_alu_ops", perf_alu_ops, 64'(ref_ops));
      check("perf_m_bubbles", perf_m_bubbles, 64'(ref_bub));
      check("perf_cmov_squash", perf_cmov_squash, 64'(ref_sq));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
